wx_router: RTL and testbench
============================

WX_ROUTER -- requirements
Module: wx_router

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: AWADDR_M1  in  `AXI_ADDR_BITS  write address, decoded with axi_pkg ADDR_DECODER.
REQ-004 SHALL have ports: AWLEN_M1  in  `AXI_LEN_BITS  burst length minus one.
REQ-005 SHALL have ports: AWVALID_M1, AWREADY_M1  in  1 each  AW handshake as seen at the AW crossbar.
REQ-006 SHALL have ports: WDATA_M1  in  `AXI_DATA_BITS; WSTRB_M1  in  `AXI_STRB_BITS; WLAST_M1, WVALID_M1  in  1; WREADY_M1  out  1.
REQ-007 SHALL have ports: WDATA_Sn, WSTRB_Sn, WLAST_Sn, WVALID_Sn  out (master widths); WREADY_Sn  in  1; for n = 0..6.
REQ-008 SHALL have ports: WERR  out  1  burst-length mismatch pulse (REQ-025).

Function
REQ-009 SHALL use FSM states IDLE and DATA, plus a registered one-hot target (7 slave bits plus DROP).
REQ-010 AW handshake = AWVALID_M1 & AWREADY_M1 in the same cycle.
REQ-011 On an AW handshake in IDLE, SHALL register target = ADDR_DECODER(AWADDR_M1) and go to DATA on the next edge.
REQ-012 An all-zero decode SHALL register target DROP.
REQ-013 In IDLE, SHALL drive WREADY_M1 = 0 and every WVALID_Sn = 0; early W data waits.
REQ-014 In DATA with slave target k, SHALL drive WVALID_Sk = WVALID_M1 and WREADY_M1 = WREADY_Sk, combinationally with zero latency; every other WVALID_Sn = 0.
REQ-015 WDATA/WSTRB/WLAST SHALL be broadcast to all slaves in every state.
REQ-016 In DATA with target DROP, SHALL drive WREADY_M1 = 1 and assert no WVALID_Sn; beats are discarded.
REQ-017 A beat is WVALID_M1 & WREADY_M1; a beat with WLAST_M1 = 1 SHALL return the FSM to IDLE on the next edge.
REQ-018 The first beat is accepted no earlier than the cycle after the AW handshake.
REQ-019 If the AW handshake and the last beat occur in the same DATA cycle, SHALL load the new target and remain in DATA.
REQ-020 An AW handshake in DATA without a last beat SHALL be ignored (AWx admits one outstanding write).
REQ-021 Target and FSM SHALL change only on AW handshake or last beat; WREADY_Sn toggling mid-burst SHALL only stall.

Reset
REQ-022 While rst = 1, SHALL set FSM = IDLE, target = none, beat counter = 0, WERR = 0.
REQ-023 Reset SHALL drive WREADY_M1 = 0 and all WVALID_Sn = 0 immediately, without waiting for clk.
REQ-024 Reset mid-burst SHALL abandon the burst; after release, a new AW handshake is required.

Configuration
REQ-025 With WX_BEAT_CHECK_EN defined:
- SHALL load an `AXI_LEN_BITS counter with AWLEN_M1 on target capture and decrement it per non-last beat.
- SHALL pulse WERR high for exactly one cycle, the cycle after a beat, when WLAST_M1 = 1 with counter ≠ 0, or WLAST_M1 = 0 with counter = 0.
- Routing SHALL be unaffected; the burst still ends on WLAST.
REQ-026 Without WX_BEAT_CHECK_EN, SHALL instantiate no counter and tie WERR to 0.

Verification
REQ-027 AW to slave 1 with AWLEN = 3, four beats 0xA0..0xA3, WREADY_S1 = 1 → WVALID_S1 follows the beats, WVALID of every other slave = 0, FSM returns to IDLE after beat 4, WERR = 0.
REQ-028 WVALID_M1 = 1 two cycles before AW handshake → WREADY_M1 = 0 until the cycle after the handshake, then data reaches the target.
REQ-029 Unmapped address, AWLEN = 1 → WREADY_M1 = 1, no WVALID_Sn asserted, IDLE after 2 beats.
REQ-030 WX_BEAT_CHECK_EN defined, AWLEN = 2, WLAST on beat 2 → WERR = 1 for one cycle, FSM goes to IDLE.
REQ-031 rst asserted between beats 2 and 3 of a 4-beat burst to slave 3 → WVALID_S3 = 0 and WREADY_M1 = 0 immediately; after release, beats are blocked until a new AW handshake.
REQ-032 Last beat to slave 0 coincides with an AW handshake to slave 2 → next cycle FSM = DATA, target = slave 2.

Source files
------------

// File: rtl/wx_router.sv
// AXI write-data router: steers one master's W channel to one of seven slaves after an AW handshake.
// Optional burst-length checking is enabled by defining WX_BEAT_CHECK_EN.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

package axi_pkg;
  // Slave n owns the 256 MB region starting at n * 0x1000_0000; regions 7..15 are unmapped.
  function automatic logic [6:0] ADDR_DECODER(input logic [`AXI_ADDR_BITS-1:0] addr);
    logic [`AXI_ADDR_BITS-1:0] region;
    logic [6:0] sel;
    region = addr >> 28;
    sel = '0;
    for (int i = 0; i < 7; i++) sel[i] = (region == `AXI_ADDR_BITS'(i));
    return sel;
  endfunction
endpackage

module wx_router (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [`AXI_ADDR_BITS-1:0] AWADDR_M1,
  input  logic [`AXI_LEN_BITS-1:0]  AWLEN_M1,
  input  logic                      AWVALID_M1,
  input  logic                      AWREADY_M1,
  input  logic [`AXI_DATA_BITS-1:0] WDATA_M1,
  input  logic [`AXI_STRB_BITS-1:0] WSTRB_M1,
  input  logic                      WLAST_M1,
  input  logic                      WVALID_M1,
  output logic                      WREADY_M1,
  output logic [`AXI_DATA_BITS-1:0] WDATA_S0, WDATA_S1, WDATA_S2, WDATA_S3, WDATA_S4, WDATA_S5, WDATA_S6,
  output logic [`AXI_STRB_BITS-1:0] WSTRB_S0, WSTRB_S1, WSTRB_S2, WSTRB_S3, WSTRB_S4, WSTRB_S5, WSTRB_S6,
  output logic                      WLAST_S0, WLAST_S1, WLAST_S2, WLAST_S3, WLAST_S4, WLAST_S5, WLAST_S6,
  output logic                      WVALID_S0, WVALID_S1, WVALID_S2, WVALID_S3, WVALID_S4, WVALID_S5, WVALID_S6,
  input  logic                      WREADY_S0, WREADY_S1, WREADY_S2, WREADY_S3, WREADY_S4, WREADY_S5, WREADY_S6,
  output logic                      WERR
);

  typedef enum logic {IDLE, DATA} state_t;

  state_t      state, state_next;
  logic [7:0]  target, target_next;
  logic [6:0]  decoded;
  logic [6:0]  wready_s;
  logic [6:0]  wvalid_s;
  logic        aw_hs, load, in_data, beat, last_beat;

  assign aw_hs     = AWVALID_M1 & AWREADY_M1;
  assign decoded   = axi_pkg::ADDR_DECODER(AWADDR_M1);
  assign beat      = WVALID_M1 & WREADY_M1;
  assign last_beat = beat & WLAST_M1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      target <= '0;
    end else begin
      state  <= state_next;
      target <= target_next;
    end
  end

  // A last beat coinciding with a new AW hands straight over to the new target.
  always_comb begin
    state_next  = state;
    target_next = target;
    load        = 1'b0;
    case (state)
      IDLE: if (aw_hs) begin
        load       = 1'b1;
        state_next = DATA;
      end
      DATA: if (last_beat) begin
        load       = aw_hs;
        state_next = aw_hs ? DATA : IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (load) target_next = (decoded == 7'd0) ? 8'b1000_0000 : {1'b0, decoded};
  end

  assign wready_s = {WREADY_S6, WREADY_S5, WREADY_S4, WREADY_S3, WREADY_S2, WREADY_S1, WREADY_S0};

  // Gating with rst keeps the outputs quiet from the instant reset rises.
  assign in_data   = (state == DATA) & ~rst;
  assign WREADY_M1 = in_data & (target[7] | (|(target[6:0] & wready_s)));
  assign wvalid_s  = {7{in_data & WVALID_M1}} & target[6:0];

  assign {WVALID_S6, WVALID_S5, WVALID_S4, WVALID_S3, WVALID_S2, WVALID_S1, WVALID_S0} = wvalid_s;

  assign WDATA_S0 = WDATA_M1;  assign WSTRB_S0 = WSTRB_M1;  assign WLAST_S0 = WLAST_M1;
  assign WDATA_S1 = WDATA_M1;  assign WSTRB_S1 = WSTRB_M1;  assign WLAST_S1 = WLAST_M1;
  assign WDATA_S2 = WDATA_M1;  assign WSTRB_S2 = WSTRB_M1;  assign WLAST_S2 = WLAST_M1;
  assign WDATA_S3 = WDATA_M1;  assign WSTRB_S3 = WSTRB_M1;  assign WLAST_S3 = WLAST_M1;
  assign WDATA_S4 = WDATA_M1;  assign WSTRB_S4 = WSTRB_M1;  assign WLAST_S4 = WLAST_M1;
  assign WDATA_S5 = WDATA_M1;  assign WSTRB_S5 = WSTRB_M1;  assign WLAST_S5 = WLAST_M1;
  assign WDATA_S6 = WDATA_M1;  assign WSTRB_S6 = WSTRB_M1;  assign WLAST_S6 = WLAST_M1;

`ifdef WX_BEAT_CHECK_EN
  logic [`AXI_LEN_BITS-1:0] beat_cnt;
  logic                     werr_q;

  // Counter holds the beats still owed before WLAST; it saturates at zero on over-long bursts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      werr_q   <= 1'b0;
    end else begin
      werr_q <= beat & (WLAST_M1 ? (beat_cnt != '0) : (beat_cnt == '0));
      if (load)
        beat_cnt <= AWLEN_M1;
      else if (beat & ~WLAST_M1 & (beat_cnt != '0))
        beat_cnt <= beat_cnt - 1'b1;
    end
  end

  assign WERR = werr_q;
`else
  logic unused_len;
  assign unused_len = ^AWLEN_M1;
  assign WERR       = 1'b0;
`endif

endmodule

// File: tb/tb_wx_router.sv
// Directed self-checking bench for wx_router; expected WERR follows WX_BEAT_CHECK_EN.
`timescale 1ns/1ps
module tb_wx_router;

`ifdef WX_BEAT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk, rst;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid;
  logic [6:0]  wready_s;
  wire         wready_m1, werr;
  wire  [6:0]  wvalid_s, wlast_s;
  wire  [31:0] wdata_s [7];
  wire  [3:0]  wstrb_s [7];

  int checks   = 0;
  int failures = 0;

  wx_router dut (
    .clk(clk), .rst(rst),
    .AWADDR_M1(awaddr), .AWLEN_M1(awlen), .AWVALID_M1(awvalid), .AWREADY_M1(awready),
    .WDATA_M1(wdata), .WSTRB_M1(wstrb), .WLAST_M1(wlast), .WVALID_M1(wvalid), .WREADY_M1(wready_m1),
    .WDATA_S0(wdata_s[0]), .WDATA_S1(wdata_s[1]), .WDATA_S2(wdata_s[2]), .WDATA_S3(wdata_s[3]),
    .WDATA_S4(wdata_s[4]), .WDATA_S5(wdata_s[5]), .WDATA_S6(wdata_s[6]),
    .WSTRB_S0(wstrb_s[0]), .WSTRB_S1(wstrb_s[1]), .WSTRB_S2(wstrb_s[2]), .WSTRB_S3(wstrb_s[3]),
    .WSTRB_S4(wstrb_s[4]), .WSTRB_S5(wstrb_s[5]), .WSTRB_S6(wstrb_s[6]),
    .WLAST_S0(wlast_s[0]), .WLAST_S1(wlast_s[1]), .WLAST_S2(wlast_s[2]), .WLAST_S3(wlast_s[3]),
    .WLAST_S4(wlast_s[4]), .WLAST_S5(wlast_s[5]), .WLAST_S6(wlast_s[6]),
    .WVALID_S0(wvalid_s[0]), .WVALID_S1(wvalid_s[1]), .WVALID_S2(wvalid_s[2]), .WVALID_S3(wvalid_s[3]),
    .WVALID_S4(wvalid_s[4]), .WVALID_S5(wvalid_s[5]), .WVALID_S6(wvalid_s[6]),
    .WREADY_S0(wready_s[0]), .WREADY_S1(wready_s[1]), .WREADY_S2(wready_s[2]), .WREADY_S3(wready_s[3]),
    .WREADY_S4(wready_s[4]), .WREADY_S5(wready_s[5]), .WREADY_S6(wready_s[6]),
    .WERR(werr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle's inputs on the falling edge and leaves 1 ns for combinational settling.
  task automatic apply_stimulus(input logic aw_v, input logic [31:0] aw_a, input logic [3:0] aw_l,
                                input logic w_v, input logic [31:0] w_d, input logic w_l,
                                input logic [6:0] ws);
    @(negedge clk);
    awvalid  = aw_v;
    awready  = aw_v;
    awaddr   = aw_a;
    awlen    = aw_l;
    wvalid   = w_v;
    wdata    = w_d;
    wstrb    = w_d[3:0];
    wlast    = w_l;
    wready_s = ws;
    #1;
  endtask

  initial begin
    rst = 1'b1; awaddr = '0; awlen = '0; awvalid = 1'b0; awready = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b1; wready_s = 7'h7F;
    #2;
    check_output("reset_wready", wready_m1, 0);
    check_output("reset_wvalid", wvalid_s, 0);
    check_output("reset_werr", werr, 0);

    // Early W data waits in IDLE, then a 4-beat burst to slave 1 with a stall and an ignored AW.
    @(negedge clk); rst = 1'b0;
    apply_stimulus(0, 0, 0, 1, 32'hA0, 0, 7'h7F);
    check_output("early_wready_c1", wready_m1, 0);
    check_output("early_wvalid_c1", wvalid_s, 0);
    apply_stimulus(0, 0, 0, 1, 32'hA0, 0, 7'h7F);
    check_output("early_wready_c2", wready_m1, 0);
    apply_stimulus(1, 32'h1000_0040, 3, 1, 32'hA0, 0, 7'h7F);
    check_output("aw_cycle_wready", wready_m1, 0);
    check_output("aw_cycle_wvalid", wvalid_s, 0);
    apply_stimulus(0, 0, 0, 1, 32'hA0, 0, 7'h7F);
    check_output("s1_b0_wready", wready_m1, 1);
    check_output("s1_b0_wvalid", wvalid_s, 7'b0000010);
    check_output("s1_b0_wdata", wdata_s[1], 32'hA0);
    apply_stimulus(1, 32'h4000_0000, 0, 1, 32'hA1, 0, 7'h7F);
    check_output("s1_b1_wvalid", wvalid_s, 7'b0000010);
    check_output("bcast_wdata_s3", wdata_s[3], 32'hA1);
    check_output("bcast_wstrb_s6", wstrb_s[6], 4'h1);
    apply_stimulus(0, 0, 0, 1, 32'hA2, 0, 7'b1111101);
    check_output("s1_stall_wready", wready_m1, 0);
    check_output("s1_stall_wvalid", wvalid_s, 7'b0000010);
    apply_stimulus(0, 0, 0, 1, 32'hA2, 0, 7'h7F);
    check_output("s1_b2_wvalid_after_ignored_aw", wvalid_s, 7'b0000010);
    apply_stimulus(0, 0, 0, 1, 32'hA3, 1, 7'h7F);
    check_output("s1_b3_wready", wready_m1, 1);
    check_output("bcast_wlast", wlast_s, 7'h7F);
    apply_stimulus(0, 0, 0, 1, 32'hB0, 0, 7'h7F);
    check_output("s1_done_idle_wready", wready_m1, 0);
    check_output("s1_done_idle_wvalid", wvalid_s, 0);
    check_output("s1_done_werr", werr, 0);

    // Unmapped address drops two beats with no slave involvement.
    apply_stimulus(1, 32'hF000_0000, 1, 0, 0, 0, 7'h00);
    apply_stimulus(0, 0, 0, 1, 32'hC0, 0, 7'h00);
    check_output("drop_b0_wready", wready_m1, 1);
    check_output("drop_b0_wvalid", wvalid_s, 0);
    apply_stimulus(0, 0, 0, 1, 32'hC1, 1, 7'h00);
    check_output("drop_b1_wready", wready_m1, 1);
    apply_stimulus(0, 0, 0, 1, 32'hC2, 0, 7'h7F);
    check_output("drop_done_idle", wready_m1, 0);
    check_output("drop_werr", werr, 0);

    // Last beat to slave 0 coincides with a new AW to slave 2.
    apply_stimulus(1, 32'h0000_0100, 1, 0, 0, 0, 7'h7F);
    apply_stimulus(0, 0, 0, 1, 32'hD0, 0, 7'h7F);
    check_output("s0_b0_wvalid", wvalid_s, 7'b0000001);
    apply_stimulus(1, 32'h2000_0000, 1, 1, 32'hD1, 1, 7'h7F);
    check_output("s0_b1_wvalid", wvalid_s, 7'b0000001);
    apply_stimulus(0, 0, 0, 1, 32'hE0, 0, 7'b0000100);
    check_output("s2_b0_wvalid", wvalid_s, 7'b0000100);
    check_output("s2_b0_wready", wready_m1, 1);
    apply_stimulus(0, 0, 0, 1, 32'hE1, 1, 7'b1111011);
    check_output("s2_stall_wready", wready_m1, 0);
    apply_stimulus(0, 0, 0, 1, 32'hE1, 1, 7'b0000100);
    check_output("s2_b1_wready", wready_m1, 1);
    apply_stimulus(0, 0, 0, 1, 32'hE2, 0, 7'h7F);
    check_output("s2_done_idle", wready_m1, 0);
    check_output("s2_werr", werr, 0);

    // Reset between beats 2 and 3 of a burst to slave 3.
    apply_stimulus(1, 32'h3000_0000, 3, 0, 0, 0, 7'h7F);
    apply_stimulus(0, 0, 0, 1, 32'hF0, 0, 7'h7F);
    check_output("s3_b0_wvalid", wvalid_s, 7'b0001000);
    apply_stimulus(0, 0, 0, 1, 32'hF1, 0, 7'h7F);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("rst_mid_wvalid", wvalid_s, 0);
    check_output("rst_mid_wready", wready_m1, 0);
    @(negedge clk); rst = 1'b0;
    apply_stimulus(0, 0, 0, 1, 32'hF2, 0, 7'h7F);
    check_output("post_rst_wready_c1", wready_m1, 0);
    check_output("post_rst_wvalid_c1", wvalid_s, 0);
    apply_stimulus(0, 0, 0, 1, 32'hF2, 0, 7'h7F);
    check_output("post_rst_wready_c2", wready_m1, 0);

    // Burst-length checking: AWLEN=2 ended early, then AWLEN=0 with an extra beat.
    apply_stimulus(1, 32'h5000_0000, 2, 0, 0, 0, 7'h7F);
    apply_stimulus(0, 0, 0, 1, 32'h11, 0, 7'h7F);
    check_output("len2_b0_wvalid", wvalid_s, 7'b0100000);
    apply_stimulus(0, 0, 0, 1, 32'h12, 1, 7'h7F);
    check_output("len2_b1_werr_before", werr, 0);
    apply_stimulus(0, 0, 0, 1, 32'h13, 0, 7'h7F);
    check_output("len2_short_werr", werr, {31'd0, CHK});
    check_output("len2_short_idle", wready_m1, 0);
    apply_stimulus(1, 32'h6000_0000, 0, 0, 0, 0, 7'h7F);
    check_output("werr_one_cycle", werr, 0);
    apply_stimulus(0, 0, 0, 1, 32'h21, 0, 7'h7F);
    check_output("len0_b0_wvalid", wvalid_s, 7'b1000000);
    apply_stimulus(0, 0, 0, 1, 32'h22, 1, 7'h7F);
    check_output("len0_long_werr", werr, {31'd0, CHK});
    check_output("len0_b1_wready", wready_m1, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 7'h7F);
    check_output("len0_last_werr", werr, 0);
    check_output("len0_done_idle", wready_m1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
